// File: rtl/seq_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_pattern_gen                                              |
// | Description : Frame generator for a serial sequence detector. Each frame   |
// |               is a run of W=1 preamble cycles, then the payload MSB first, |
// |               then one GAP cycle that carries the done pulse.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_pattern_gen #(
  parameter int WIDTH        = 8,
  parameter int PREAMBLE_LEN = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             W,
  output logic             _W,
  output logic             W_valid,
  output logic             busy,
  output logic             done
);

  // One counter serves both the preamble and the payload phases, so it has
  // to reach the longer of the two.
  localparam int MAX_CNT = (PREAMBLE_LEN > WIDTH) ? PREAMBLE_LEN : WIDTH;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CW-1:0] C_PRE_LAST  = CW'(PREAMBLE_LEN - 1);
  localparam logic [CW-1:0] C_DATA_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;

  // State, counter and payload shift register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state logic: start is only looked at in IDLE, and the counter is
  // cleared on every state change so each phase counts from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          shreg_d = data_in;
          state_d = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        if (cnt_q == C_PRE_LAST) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        shreg_d = shreg_q << 1;
        if (cnt_q == C_DATA_LAST) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore outputs decoded purely from registered state.
  always_comb begin
    W       = 1'b0;
    W_valid = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_PREAMBLE: begin
        W       = 1'b1;
        W_valid = 1'b1;
        busy    = 1'b1;
      end
      ST_DATA: begin
        W       = shreg_q[WIDTH-1];
        W_valid = 1'b1;
        busy    = 1'b1;
      end
      ST_GAP: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        W       = 1'b0;
        W_valid = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
      end
    endcase
  end

  assign _W = ~W;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seq_pattern_gen                                           |
// | Description : Directed scoreboard bench for seq_pattern_gen.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seq_pattern_gen;

  localparam int WIDTH        = 8;
  localparam int PREAMBLE_LEN = 2;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             dut_w;
  logic             dut_w_n;
  logic             dut_w_valid;
  logic             dut_busy;
  logic             dut_done;

  seq_pattern_gen #(
    .WIDTH       (WIDTH),
    .PREAMBLE_LEN(PREAMBLE_LEN)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .data_in(data_in),
    .W      (dut_w),
    ._W     (dut_w_n),
    .W_valid(dut_w_valid),
    .busy   (dut_busy),
    .done   (dut_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected per-cycle outputs: {W, W_valid, busy, done}
  typedef struct packed {
    logic w;
    logic v;
    logic b;
    logic d;
  } exp_t;

  localparam exp_t C_IDLE = '{w: 1'b0, v: 1'b0, b: 1'b0, d: 1'b0};

  exp_t exp_q[$];
  int   checks;
  int   errors;
  logic model_idle;

  // Queue the whole expected frame for a payload accepted in IDLE.
  task automatic push_frame(input logic [WIDTH-1:0] d);
    for (int i = 0; i < PREAMBLE_LEN; i++)
      exp_q.push_back('{w: 1'b1, v: 1'b1, b: 1'b1, d: 1'b0});
    for (int i = WIDTH - 1; i >= 0; i--)
      exp_q.push_back('{w: d[i], v: 1'b1, b: 1'b1, d: 1'b0});
    exp_q.push_back('{w: 1'b0, v: 1'b0, b: 1'b1, d: 1'b1});
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, then compare
  // the outputs at the following falling edge against the scoreboard head.
  task automatic tick(input logic s, input logic [WIDTH-1:0] d, input logic r,
                      input string tag);
    exp_t exp_v;
    exp_t obs_v;
    reset   = r;
    start   = s;
    data_in = d;
    if (r) begin
      exp_q.delete();
      exp_q.push_back(C_IDLE);
    end else if (model_idle && s && exp_q.size() == 0) begin
      push_frame(d);
    end else if (exp_q.size() == 0) begin
      exp_q.push_back(C_IDLE);
    end
    @(posedge clk);
    @(negedge clk);
    exp_v      = exp_q.pop_front();
    model_idle = ~exp_v.b;
    obs_v      = '{w: dut_w, v: dut_w_valid, b: dut_busy, d: dut_done};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s outputs{W,valid,busy,done} observed=%b expected=%b",
             tag, obs_v, exp_v);
    end
    checks++;
    assert (dut_w_n === ~exp_v.w) else begin
      errors++;
      $error("FAIL %s_Wbar observed=%b expected=%b", tag, dut_w_n, ~exp_v.w);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    model_idle = 1'b0;
    reset      = 1'b1;
    start      = 1'b0;
    data_in    = '0;
    @(negedge clk);

    // Reset, with start asserted to confirm reset priority, then idle.
    tick(1'b1, 8'hFF, 1'b1, "reset_prio");
    tick(1'b0, 8'h00, 1'b1, "reset");
    for (int i = 0; i < 5; i++) tick(1'b0, 8'h00, 1'b0, "idle");

    // Single frame with A5, data_in scrambled while in flight.
    tick(1'b1, 8'hA5, 1'b0, "a5_accept");
    for (int i = 0; i < 12; i++)
      tick(1'b0, WIDTH'($urandom), 1'b0, "a5_frame");

    // All-zero payload.
    tick(1'b1, 8'h00, 1'b0, "zero_accept");
    for (int i = 0; i < 12; i++) tick(1'b0, 8'h00, 1'b0, "zero_frame");

    // start re-pulsed during DATA with FF must be ignored.
    tick(1'b1, 8'hA5, 1'b0, "repulse_accept");
    for (int i = 0; i < 4; i++) tick(1'b0, 8'hA5, 1'b0, "repulse_frame");
    tick(1'b1, 8'hFF, 1'b0, "repulse_ignored");
    for (int i = 0; i < 8; i++) tick(1'b0, 8'hFF, 1'b0, "repulse_tail");

    // start held high: back-to-back frames with one IDLE cycle between.
    for (int i = 0; i < 24; i++) tick(1'b1, 8'h81, 1'b0, "held_81");
    for (int i = 0; i < 14; i++) tick(1'b0, 8'h81, 1'b0, "held_tail");

    // Reset in the third DATA cycle, then a clean 3C frame right after.
    tick(1'b1, 8'hC3, 1'b0, "abort_accept");
    for (int i = 0; i < 4; i++) tick(1'b0, 8'hC3, 1'b0, "abort_frame");
    tick(1'b0, 8'hC3, 1'b1, "abort_reset");
    tick(1'b1, 8'h3C, 1'b0, "3c_accept");
    for (int i = 0; i < 13; i++) tick(1'b0, 8'h00, 1'b0, "3c_frame");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 Parameter WIDTH, default 8, number of payload bits per frame (legal range 1..32).
REQ-002 Parameter PREAMBLE_LEN, default 2, number of consecutive W=1 marker cycles preceding the payload (legal range 1..8).
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  reset is synchronous and active-high.
REQ-005 Port start  input  1  request to transmit one frame; sampled only in IDLE.
REQ-006 Port data_in  input  WIDTH  payload; captured on the accepting edge.
REQ-007 Port W  output  1  serial bit stream toward the sequence detector.
REQ-008 Port _W  output  1  complement of W, always ~W, including during reset.
REQ-009 Port W_valid  output  1  high when W carries a frame bit (preamble or payload).
REQ-010 Port busy  output  1  high from the cycle after acceptance until return to IDLE.
REQ-011 Port done  output  1  one-cycle pulse marking end of frame.

Function
REQ-012 The block SHALL be a Moore FSM: W, _W, W_valid, busy and done SHALL depend only on registered state, never combinationally on start or data_in.
REQ-013 States SHALL be IDLE, PREAMBLE, DATA, GAP; encoding is free but SHALL be fully decoded, with any unused encoding transitioning to IDLE on the next edge.
REQ-014 IDLE outputs: W=0, W_valid=0, busy=0, done=0.
REQ-015 IDLE with start=1 at edge k: shift register <= data_in, bit counter <= 0, state <= PREAMBLE; first preamble bit visible after edge k (latency 1 cycle).
REQ-016 PREAMBLE: W=1, W_valid=1, busy=1; stays exactly PREAMBLE_LEN cycles, then DATA.
REQ-017 DATA: W = current MSB of shift register, W_valid=1, busy=1; register shifts left by one (zero fill) each cycle; exactly WIDTH cycles, then GAP.
REQ-018 Payload SHALL be transmitted MSB first: bit WIDTH-1 in the first DATA cycle, bit 0 in the last.
REQ-019 GAP: W=0, W_valid=0, busy=1, done=1 for exactly one cycle, then IDLE.
REQ-020 Frame length from first PREAMBLE cycle through GAP SHALL be PREAMBLE_LEN+WIDTH+1 cycles.
REQ-021 start asserted in PREAMBLE, DATA or GAP SHALL be ignored (not queued); data_in changes during a frame SHALL not affect the frame in flight.
REQ-022 start held high continuously SHALL produce back-to-back frames separated by exactly one IDLE cycle after GAP.
REQ-023 Bit counter SHALL be sized to hold max(PREAMBLE_LEN, WIDTH)-1 without overflow and SHALL be cleared on every state transition.

Reset
REQ-024 reset=1 at any edge SHALL force state=IDLE, shift register=0, counter=0, giving W=0, _W=1, W_valid=0, busy=0, done=0 after that edge.
REQ-025 reset SHALL take priority over start on the same edge; a frame interrupted by reset SHALL be abandoned with no done pulse.
REQ-026 First start after reset deasserts SHALL be accepted normally on the next edge.

Verification
REQ-027 Reset then idle 5 cycles -> W=0, _W=1, W_valid=0, busy=0, done=0 throughout.
REQ-028 Defaults, start one cycle with data_in=8'hA5 -> W sequence 1,1,1,0,1,0,0,1,0,1 with W_valid=1 for those 10 cycles, then GAP with done=1, W_valid=0; busy high 11 cycles.
REQ-029 data_in=8'h00, start pulse -> W = 1,1 then eight 0s with W_valid=1; done pulse on cycle 11 after acceptance.
REQ-030 start re-pulsed during DATA with data_in=8'hFF -> ignored; frame bits unchanged; single done pulse.
REQ-031 start held high, data_in=8'h81 -> two identical frames, one IDLE cycle between GAP and next PREAMBLE.
REQ-032 reset asserted in third DATA cycle -> next cycle IDLE outputs, no done pulse; subsequent start with 8'h3C transmits 1,1,0,0,1,1,1,1,0,0 correctly.
